// File: rtl/aes_key_expander.sv
// aes_key_expander: iterative AES-128/192/256 key schedule, one word/clock.
// Round keys leave over a valid/ready handshake; optional key store.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start, key_in   begin expansion of key_in (honoured when idle)
//   busy, done      expansion in progress / one-cycle completion pulse
//   rk_valid/ready  round-key handshake; rk_idx, rk_out = round no. / key
//   rd_idx, rd_key  stored round-key read port (combinational)
//
// Config macro KEYEXP_STORE_EN: builds an NR+1 entry round-key store
// behind rd_idx/rd_key; without it rd_key is tied to zero.

module s_box (
  output logic [7:0] sbox_o,
  input  logic [7:0] sbox_i
);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] sq;
  logic [7:0] inv;

  // inverse = x^254 = x^2 * x^4 * ... * x^128 (0 maps to 0)
  always_comb begin
    sq  = gf_mul(sbox_i, sbox_i);
    inv = sq;
    for (int k = 2; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    sbox_o = inv
           ^ {inv[6:0], inv[7]}
           ^ {inv[5:0], inv[7:6]}
           ^ {inv[4:0], inv[7:5]}
           ^ {inv[3:0], inv[7:4]}
           ^ 8'h63;
  end

endmodule

module aes_key_expander #(
  parameter int KEY_BITS = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [KEY_BITS-1:0] key_in,
  output logic                busy,
  output logic                rk_valid,
  input  logic                rk_ready,
  output logic [3:0]          rk_idx,
  output logic [127:0]        rk_out,
  output logic                done,
  input  logic [3:0]          rd_idx,
  output logic [127:0]        rd_key
);

  localparam int NK = KEY_BITS / 32;
  localparam int NR = NK + 6;
  localparam logic [5:0] LAST_W = 6'(4 * (NR + 1));
  localparam logic [3:0] LAST_R = 4'(NR);
  localparam logic [2:0] PH_MAX = 3'(NK - 1);
  localparam logic [5:0] NK_W   = 6'(NK);

  if (!(KEY_BITS == 128 || KEY_BITS == 192 || KEY_BITS == 256))
  begin : g_bad_key_bits
    $error("aes_key_expander: KEY_BITS must be 128, 192 or 256");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_HOLD,
    S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [KEY_BITS-1:0]  key_q;
  logic [NK-1:0][31:0]  win_q;
  logic [95:0]          asm_q;
  logic [5:0]           i_q;
  logic [2:0]           ph_q;
  logic [7:0]           rcon_q;
  logic                 rk_valid_q;
  logic [3:0]           rk_idx_q;
  logic [127:0]         rk_out_q;

  logic        start_ok;
  logic        hs;
  logic        gen_en;
  logic        rk_load;
  logic        load_key;
  logic        use_rot;
  logic        use_sub;
  logic [31:0] prev_w;
  logic [31:0] old_w;
  logic [31:0] sb_in;
  logic [31:0] sb_out;
  logic [31:0] w_new;

  assign busy     = (state_q == S_GEN) || (state_q == S_HOLD);
  assign done     = (state_q == S_DONE);
  assign rk_valid = rk_valid_q;
  assign rk_idx   = rk_idx_q;
  assign rk_out   = rk_out_q;

  assign start_ok = (state_q == S_IDLE) && start;
  assign hs       = rk_valid_q && rk_ready;
  // a presented but unaccepted key freezes the whole schedule
  assign gen_en   = busy && (i_q != LAST_W)
                 && (!rk_valid_q || rk_ready);
  assign rk_load  = gen_en && (i_q[1:0] == 2'd3);

  assign prev_w   = win_q[0];
  assign old_w    = win_q[NK-1];
  assign load_key = (i_q < NK_W);
  assign use_rot  = !load_key && (ph_q == 3'd0);
  assign use_sub  = !load_key && (NK == 8) && (ph_q == 3'd4);
  assign sb_in    = use_rot ? {prev_w[23:0], prev_w[31:24]} : prev_w;

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    s_box u_sbox (sb_out[8*b +: 8], sb_in[8*b +: 8]);
  end

  always_comb begin
    w_new = old_w ^ prev_w;
    unique case (1'b1)
      load_key: w_new = key_q[KEY_BITS-1 -: 32];
      use_rot:  w_new = old_w ^ sb_out ^ {rcon_q, 24'h0};
      use_sub:  w_new = old_w ^ sb_out;
      default:  w_new = old_w ^ prev_w;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_GEN;
      S_GEN: begin
        if (hs && rk_idx_q == LAST_R) state_d = S_DONE;
        else if (rk_valid_q && !rk_ready) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (rk_ready)
          state_d = (rk_idx_q == LAST_R) ? S_DONE : S_GEN;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q      <= '0;
      win_q      <= '0;
      asm_q      <= '0;
      i_q        <= '0;
      ph_q       <= '0;
      rcon_q     <= 8'h01;
      rk_valid_q <= 1'b0;
      rk_idx_q   <= '0;
      rk_out_q   <= '0;
    end else if (start_ok) begin
      key_q      <= key_in;
      win_q      <= '0;
      asm_q      <= '0;
      i_q        <= '0;
      ph_q       <= '0;
      rcon_q     <= 8'h01;
      rk_valid_q <= 1'b0;
    end else begin
      if (hs) rk_valid_q <= 1'b0;
      if (gen_en) begin
        key_q <= {key_q[KEY_BITS-33:0], 32'h0};
        win_q <= {win_q[NK-2:0], w_new};
        asm_q <= {asm_q[63:0], w_new};
        i_q   <= i_q + 6'd1;
        ph_q  <= (ph_q == PH_MAX) ? 3'd0 : ph_q + 3'd1;
        if (use_rot)
          rcon_q <= {rcon_q[6:0], 1'b0}
                  ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (rk_load) begin
          rk_out_q   <= {asm_q, w_new};
          rk_valid_q <= 1'b1;
          rk_idx_q   <= i_q[5:2];
        end
      end
    end
  end

`ifdef KEYEXP_STORE_EN
  logic [127:0] store_q [NR+1];

  always_ff @(posedge clk) begin
    if (rst || start_ok) begin
      for (int e = 0; e <= NR; e++) store_q[e] <= '0;
    end else if (rk_load) begin
      store_q[i_q[5:2]] <= {asm_q, w_new};
    end
  end

  assign rd_key = (rd_idx <= LAST_R) ? store_q[rd_idx] : '0;
`else
  logic unused_rd;
  assign unused_rd = ^rd_idx;
  assign rd_key    = '0;
`endif

endmodule
